am_modulator: RTL

Baseband AM modulator for the transmit path: accepts signed 8-bit audio samples on a strobe, forms a carrier-plus-sideband envelope scaled by a programmable modulation depth, and emits 8-bit signed I/Q samples for the upconversion chain. It sits opposite the receive-side AM demodulator. Its I/Q output format (two's complement, 8-bit) is what that demodulator consumes, so the two can be looped back for test. An optional fs/4 quadrature rotation shifts the carrier off DC.

---
 rtl/am_modulator_if.sv | 23 ++
 rtl/am_modulator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/am_modulator_if.sv
// Sample/IQ bundle between the audio source and the AM modulator.
// The master drives audio samples and settings; the slave returns I/Q and status.
interface am_modulator_if;
    logic [7:0] d_in;
    logic       d_valid;
    logic [7:0] mod_depth;
    logic       rot_en;
    logic [7:0] I_out;
    logic [7:0] Q_out;
    logic       out_valid;
    logic       busy;
    logic       overrun;

    modport master (
        output d_in, d_valid, mod_depth, rot_en,
        input  I_out, Q_out, out_valid, busy, overrun
    );

    modport slave (
        input  d_in, d_valid, mod_depth, rot_en,
        output I_out, Q_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/am_modulator.sv
// Baseband AM modulator: signed audio sample -> carrier-plus-sideband envelope
// -> 8-bit signed I/Q, with optional fs/4 carrier rotation.
// One sample in flight at a time; four clocks per sample (IDLE/MULT/SCALE/EMIT).
module am_modulator (
    input  logic        clk,
    input  logic        rst,
    am_modulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        SCALE = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic        [7:0]  din_q, din_d;
    logic        [7:0]  depth_q, depth_d;
    logic signed [15:0] prod_q, prod_d;
    logic        [6:0]  env_q, env_d;
    logic        [1:0]  phase_q, phase_d;
    logic        [7:0]  i_q, i_d;
    logic        [7:0]  q_q, q_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    // Operands widened to 16 bits: audio sign-extended, depth zero-extended,
    // so the 16-bit product of the widened values is the exact signed result.
    logic signed [15:0] din_ext;
    logic signed [15:0] depth_ext;
    assign din_ext   = {{8{din_q[7]}}, din_q};
    assign depth_ext = {8'd0, depth_q};

    // Envelope as positive and negated 8-bit two's complement (-0 stays 0).
    logic [7:0] env_pos;
    logic [7:0] env_neg;
    logic [1:0] phase_eff;
    assign env_pos   = {1'b0, env_q};
    assign env_neg   = 8'd0 - env_pos;
    assign phase_eff = bus.rot_en ? phase_q : 2'd0;

    // Next-state and datapath: one pipeline step per FSM state.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        din_d     = din_q;
        depth_d   = depth_q;
        prod_d    = prod_q;
        env_d     = env_q;
        phase_d   = phase_q;
        i_d       = i_q;
        q_d       = q_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        // A strobe while a sample is in flight is dropped and flagged.
        if (bus.d_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.d_valid) begin
                    din_d   = bus.d_in;
                    depth_d = bus.mod_depth;
                    state_d = MULT;
                end
            end
            MULT: begin
                prod_d  = din_ext * depth_ext;
                state_d = SCALE;
            end
            SCALE: begin
                // Product range limits the sum to 0..127, so 7 bits are exact.
                env_d   = 7'(16'sd64 + (prod_q >>> 9));
                state_d = EMIT;
            end
            EMIT: begin
                case (phase_eff)
                    2'd0:    begin i_d = env_pos; q_d = 8'd0;    end
                    2'd1:    begin i_d = 8'd0;    q_d = env_pos; end
                    2'd2:    begin i_d = env_neg; q_d = 8'd0;    end
                    default: begin i_d = 8'd0;    q_d = env_neg; end
                endcase
                phase_d = bus.rot_en ? (phase_q + 2'd1) : 2'd0;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            din_q     <= 8'd0;
            depth_q   <= 8'd0;
            prod_q    <= 16'sd0;
            env_q     <= 7'd0;
            phase_q   <= 2'd0;
            i_q       <= 8'd0;
            q_q       <= 8'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            din_q     <= din_d;
            depth_q   <= depth_d;
            prod_q    <= prod_d;
            env_q     <= env_d;
            phase_q   <= phase_d;
            i_q       <= i_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.I_out     = i_q;
    assign bus.Q_out     = q_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;

endmodule
